// File: rtl/smss_sbox_scheduler.sv
// Two-port round-robin arbiter and word sequencer for a shared 6-bit S-box.
// One block is accepted at a time, streamed one word per cycle, and returned with its tag.
module smss_sbox_scheduler #(
  parameter int NWORDS = 6,
  parameter int TAGW   = 2,
  localparam int W     = 6 * NWORDS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_data,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_data,
  input  logic [TAGW-1:0] req1_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_src,
  output logic [5:0]      sbox_x,
  input  logic [5:0]      sbox_y,
  output logic            sbox_en,
  output logic            busy
);
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t                 r_state;
  logic                   r_last, r_src, r_sbox_en, r_rsp_valid;
  logic [TAGW-1:0]        r_tag;
  logic [IDXW-1:0]        r_idx;
  logic [5:0]             r_sbox_x;
  logic [NWORDS-1:0][5:0] r_data, r_res;

  logic                   w_idle, w_sel1, w_rdy0, w_rdy1, w_acc, w_last_word;
  logic [NWORDS-1:0][5:0] w_in;
  logic [IDXW-1:0]        w_nidx;

  // Tie goes to whichever port was not served last.
  assign w_idle      = (r_state == IDLE);
  assign w_sel1      = req1_valid & (~req0_valid | ~r_last);
  assign w_rdy1      = rst_n & w_idle & w_sel1;
  assign w_rdy0      = rst_n & w_idle & req0_valid & ~w_sel1;
  assign w_acc       = w_rdy0 | w_rdy1;
  assign w_in        = w_sel1 ? req1_data : req0_data;
  assign w_last_word = (r_idx == IDXW'(NWORDS - 1));
  assign w_nidx      = r_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_src       <= 1'b0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_sbox_x    <= '0;
      r_sbox_en   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_data      <= '0;
      r_res       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_data    <= w_in;
          r_tag     <= w_sel1 ? req1_tag : req0_tag;
          r_src     <= w_sel1;
          r_last    <= w_sel1;
          r_idx     <= '0;
          r_sbox_x  <= w_in[0];
          r_sbox_en <= 1'b1;
          r_state   <= RUN;
        end
        RUN: begin
          // sbox_y is the image of the word presented this cycle.
          r_res[r_idx] <= sbox_y;
          if (!w_last_word) begin
            r_idx    <= w_nidx;
            r_sbox_x <= r_data[w_nidx];
          end else begin
            r_sbox_x    <= '0;
            r_sbox_en   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_res;
  assign rsp_tag    = r_tag;
  assign rsp_src    = r_src;
  assign sbox_x     = r_sbox_x;
  assign sbox_en    = r_sbox_en;
  assign busy       = ~w_idle;
endmodule

// File: tb/tb_smss_sbox_scheduler.sv
// Bench for smss_sbox_scheduler: plays the external x^23 S-box, runs directed and random
// traffic, and compares every cycle against a counter/queue model of the scheduler.
module tb_smss_sbox_scheduler;
  localparam int NWORDS = 6;
  localparam int TAGW   = 2;
  localparam int W      = 6 * NWORDS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid, rsp_ready;
  logic            req0_ready, req1_ready, rsp_valid, rsp_src, sbox_en, busy;
  logic [W-1:0]    req0_data, req1_data, rsp_data;
  logic [TAGW-1:0] req0_tag, req1_tag, rsp_tag;
  logic [5:0]      sbox_x, sbox_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  smss_sbox_scheduler #(.NWORDS(NWORDS), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_src(rsp_src), .sbox_x(sbox_x), .sbox_y(sbox_y), .sbox_en(sbox_en), .busy(busy)
  );

  // GF(2^6) with x^6 + x + 1; x^23 is basis-independent, so the tower form gives the same map.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p = '0;
    logic [5:0] aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return p;
  endfunction

  // External S-box instance: square-and-multiply.
  function automatic logic [5:0] sbox_fn(input logic [5:0] x);
    logic [4:0] e = 5'd23;
    logic [5:0] r = 6'd1;
    for (int i = 4; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction
  assign sbox_y = sbox_fn(sbox_x);

  // Reference map: plain repeated multiplication.
  function automatic logic [5:0] mdl_s(input logic [5:0] x);
    logic [5:0] r = 6'd1;
    for (int i = 0; i < 23; i++) r = gf_mul(r, x);
    return r;
  endfunction

  function automatic logic [W-1:0] mdl_blk(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < NWORDS; i++) r[6*i +: 6] = mdl_s(d[6*i +: 6]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words still to present, a pending-response flag, and one expected result slot.
  bit         m_known = 0;
  bit         m_last;
  int         m_run, m_nacc = 0, m_nrsp = 0;
  bit         m_pend;
  logic [5:0] m_words [NWORDS];
  logic [W-1:0]    m_exp_data;
  logic [TAGW-1:0] m_exp_tag;
  bit              m_exp_src;

  always @(negedge clk) begin
    bit idle, e0, e1;
    logic [W-1:0] d;
    idle = (m_run == 0) && !m_pend;
    e1 = rst_n && idle && req1_valid && (!req0_valid || !m_last);
    e0 = rst_n && idle && req0_valid && !e1;
    if (m_known) begin
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("busy", busy, !idle);
      chk("sbox_en", sbox_en, m_run > 0);
      chk("sbox_x", sbox_x, (m_run > 0) ? m_words[NWORDS - m_run] : 6'd0);
      chk("rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
        chk("rsp_data", rsp_data, m_exp_data);
        chk("rsp_tag", rsp_tag, m_exp_tag);
        chk("rsp_src", rsp_src, m_exp_src);
      end
    end
    if (!rst_n) begin
      m_known = 1; m_run = 0; m_pend = 0; m_last = 1;
    end else if (m_known) begin
      if (e0 || e1) begin
        d = e1 ? req1_data : req0_data;
        for (int i = 0; i < NWORDS; i++) m_words[i] = d[6*i +: 6];
        m_exp_data = mdl_blk(d);
        m_exp_tag  = e1 ? req1_tag : req0_tag;
        m_exp_src  = e1;
        m_last     = e1;
        m_run      = NWORDS;
        m_nacc++;
      end else if (m_run > 0) begin
        m_run--;
        if (m_run == 0) m_pend = 1;
      end else if (m_pend && rsp_ready) begin
        m_pend = 0;
        m_nrsp++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d, e;
    int start, cyc;
    int pulses[$];
    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_data = '0; req0_tag = '0;
    req1_valid = 0; req1_data = '0; req1_tag = '0;
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_sbox_en", sbox_en, 0);
    chk("rst_sbox_x", sbox_x, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_src", rsp_src, 0);
    chk("mdl_s0", mdl_s(6'd0), 6'd0);
    chk("mdl_s1", mdl_s(6'd1), 6'd1);
    chk("mdl_s2", mdl_s(6'd2), 6'h29);
    rst_n = 1;

    // Single block of all-ones words.
    req0_valid = 1; req0_data = 36'h041041041; req0_tag = 2; rsp_ready = 1;
    #1 chk("t1_ready0", req0_ready, 1);
    step;
    req0_valid = 0;
    for (int k = 1; k <= NWORDS; k++) begin
      chk("t1_sbox_x", sbox_x, 1);
      chk("t1_sbox_en", sbox_en, 1);
      chk("t1_no_rsp", rsp_valid, 0);
      step;
    end
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 36'h041041041);
    chk("t1_rsp_tag", rsp_tag, 2);
    chk("t1_rsp_src", rsp_src, 0);
    step;
    chk("t1_idle", busy, 0);

    // Tie right after reset.
    rst_n = 0; step; rst_n = 1;
    req0_valid = 1; req0_data = '0; req0_tag = 1;
    req1_valid = 1; req1_data = 36'h041041041; req1_tag = 3;
    #1 chk("t2_ready0", req0_ready, 1);
    chk("t2_ready1", req1_ready, 0);
    step;
    req0_valid = 0;
    repeat (6) step;
    chk("t2_rsp0_valid", rsp_valid, 1);
    chk("t2_rsp0_data", rsp_data, 0);
    chk("t2_rsp0_src", rsp_src, 0);
    step;
    chk("t2_ready1_late", req1_ready, 1);
    step;
    req1_valid = 0;
    repeat (6) step;
    chk("t2_rsp1_valid", rsp_valid, 1);
    chk("t2_rsp1_data", rsp_data, 36'h041041041);
    chk("t2_rsp1_src", rsp_src, 1);
    step;

    // Back-pressure for 5 cycles with a competing request waiting.
    rsp_ready = 0;
    d = {4'($urandom), 32'($urandom)};
    e = mdl_blk(d);
    req0_valid = 1; req0_data = d; req0_tag = 0;
    step;
    req0_valid = 0; req1_valid = 1; req1_tag = 2;
    repeat (6) step;
    chk("t3_rsp_valid", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_data", rsp_data, e);
      chk("t3_hold_tag", rsp_tag, 0);
      chk("t3_hold_src", rsp_src, 0);
      chk("t3_ready0", req0_ready, 0);
      chk("t3_ready1", req1_ready, 0);
      step;
    end
    rsp_ready = 1;
    step;
    chk("t3_idle", busy, 0);
    chk("t3_ready1_after", req1_ready, 1);
    step;
    req1_valid = 0;
    repeat (9) step;

    // Random traffic.
    start = m_nacc; cyc = 0;
    while (m_nacc - start < 200 && cyc < 20000) begin
      req0_valid = ($urandom % 3) != 0;
      req1_valid = ($urandom % 3) != 0;
      req0_data = {4'($urandom), 32'($urandom)}; req0_tag = TAGW'($urandom);
      req1_data = {4'($urandom), 32'($urandom)}; req1_tag = TAGW'($urandom);
      rsp_ready = ($urandom % 2) != 0;
      step;
      cyc++;
    end
    chk("t4_blocks_done", (m_nacc - start) >= 200, 1);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (12) step;
    chk("t4_all_responded", m_nrsp, m_nacc);

    // Reset in the third RUN cycle of a req0 block.
    req0_valid = 1; req0_data = {4'($urandom), 32'($urandom)}; req0_tag = 1;
    step;
    req0_valid = 0;
    step; step;
    rst_n = 0;
    #1 chk("t5_running", sbox_en, 1);
    step;
    rst_n = 1;
    chk("t5_busy", busy, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_tag", rsp_tag, 0);
    chk("t5_rsp_src", rsp_src, 0);
    chk("t5_sbox_x", sbox_x, 0);
    chk("t5_sbox_en", sbox_en, 0);
    req0_valid = 1; req1_valid = 1;
    #1 chk("t5_tie0", req0_ready, 1);
    chk("t5_tie1", req1_ready, 0);
    step;
    req0_valid = 0; req1_valid = 0;
    repeat (9) step;

    // req1 alone, continuously valid.
    req1_valid = 1; rsp_ready = 1;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req1_ready) pulses.push_back(c);
      chk("t6_ready0", req0_ready, 0);
      if (rsp_valid) chk("t6_src", rsp_src, 1);
      step;
    end
    chk("t6_pulses", pulses.size(), 5);
    for (int i = 1; i < pulses.size(); i++) chk("t6_gap", pulses[i] - pulses[i-1], 8);
    req1_valid = 0;
    repeat (10) step;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/smss_sbox_scheduler.md
# smss_sbox_scheduler

Sequencer and two-port arbiter for the shared 6-bit SMSS S-box datapath. The S-box is the power map x^23 over GF(2^6), computed in the GF((2^3)^2) tower basis and wrapped by the isomorphism and inverse isomorphism. This block accepts multi-word blocks from two requesters and grants one at a time with round-robin priority. It streams the block's 6-bit words through one external combinational S-box instance, one word per cycle, and returns the substituted block with the requester's tag.

## Interface
- NWORDS, 6, number of 6-bit words per block (≥1); block width W = 6*NWORDS
- TAGW, 2, requester tag width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle when valid&ready
- req0_data  in  W  requester 0 block; word i = bits [6i+5:6i]
- req0_tag  in  TAGW  requester 0 tag
- req1_valid / req1_ready / req1_data / req1_tag: same as port 0, for requester 1
- rsp_valid  out  1  result block available
- rsp_ready  in  1  consumer takes result when valid&ready
- rsp_data  out  W  substituted block, word i = S(input word i)
- rsp_tag  out  TAGW  tag of the served request
- rsp_src  out  1  0 = served requester 0, 1 = served requester 1
- sbox_x  out  6  S-box input, registered
- sbox_y  in  6  S-box output, combinational function of sbox_x
- sbox_en  out  1  high while sbox_x carries a valid word
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, RESP.
- IDLE
  - Grant goes to the requester with valid high. If both are valid, grant goes to the requester that is not `last` (a 1-bit pointer naming the last-served requester).
  - reqN_ready = (state==IDLE) & grant==N, combinational from valid and `last`. Never high for both ports together; never high outside IDLE.
  - On accept: latch data, tag and src; set `last`=src; idx←0; sbox_x←word 0; sbox_en←1; go to RUN.
- RUN (NWORDS cycles)
  - Each cycle, capture sbox_y into result word idx.
  - If idx<NWORDS-1: idx←idx+1 and sbox_x←word idx+1.
  - Otherwise: sbox_x←0, sbox_en←0, rsp_valid←1, go to RESP.
- RESP
  - rsp_data, rsp_tag and rsp_src are held stable while rsp_valid=1.
  - On rsp_valid&rsp_ready: rsp_valid←0, go to IDLE.
  - No accept happens in the same cycle as a response handshake (no bypass).
- sbox_x is 0 whenever sbox_en=0. Zero is a fixed point of the S-box, so an idle sbox_x produces no spurious toggling downstream.
- Requester data is sampled only at the accept edge. Later changes on reqN_data have no effect.
- A request deasserted before being granted is dropped without any side effect.
- idx width is clog2(NWORDS), with a minimum of 1. idx never exceeds NWORDS-1.

## Timing
- Reset (rst_n=0 at a rising edge) forces the following on that edge:
  - state=IDLE, `last`=1 (so requester 0 wins the first tie)
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_src=0
  - sbox_x=0, sbox_en=0, busy=0
  - reqN_ready: 0 while rst_n=0
- Reset mid-RUN or mid-RESP aborts the block. No response is produced for it.
- Latency: accept at edge T → RUN during cycles T+1..T+NWORDS → rsp_valid=1 from cycle T+NWORDS+1.
- Throughput: minimum NWORDS+2 cycles per block with rsp_ready tied high (8 cycles at NWORDS=6).
- Back-pressure: rsp_ready low holds the block in RESP indefinitely, with both reqN_ready held at 0.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- sbox_y is sampled at the edge ending the cycle in which the matching sbox_x is presented. Required combinational path: the sbox_x register, through the S-box, into the result register, within one clk period.

## Test plan
- Reset, then req0 with data=36'h041041041 (all words 1), tag=2, rsp_ready=1. Required:
  - accept at T; sbox_x=1 in cycles T+1..T+6
  - rsp_valid at T+7 with rsp_data=36'h041041041, rsp_tag=2, rsp_src=0
  - S(1)=1
- Both requesters valid in the same cycle right after reset (req0 data 0, req1 data 36'h041041041). Required:
  - req0 accepted first; first response rsp_data=0, rsp_src=0
  - req1 accepted 8 cycles later; second response rsp_data=36'h041041041, rsp_src=1
- rsp_ready held low for 5 cycles after rsp_valid rises. Required:
  - rsp_data, rsp_tag and rsp_src stay constant; req0_ready and req1_ready stay 0
  - IDLE is entered on the cycle after rsp_ready rises
- 200 random blocks on random ports with random rsp_ready. Required:
  - sbox_x sequence is word0..word5 of each block
  - rsp_data matches a reference model of x^23 through the isomorphism, per word
  - responses arrive in grant order; tags and srcs match
- rst_n pulled low for one edge during the third RUN cycle. Required:
  - on that edge, every output is at its reset value and sbox_en=0
  - no response for the aborted block
  - a subsequent req0/req1 tie is granted to req0
- req1 alone, continuously valid, rsp_ready=1. Required:
  - req1_ready pulses exactly every 8 cycles
  - req0_ready never asserts; rsp_src=1 throughout
